alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 146 ++++++++++++++
 tb/tb_alu_multicycle.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Small ALU with single-cycle add/sub/and/or and a radix-2 shift-add
//   multiplier that retires one partial product per cycle (DATA_W steps).
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset
//   start_i      operation request, only looked at while busy_o=0
//   ALUCtrl_i    010 add, 110 sub, 000 and, 001 or, 011 mul, others -> 0
//   data1_i      operand A
//   data2_i      operand B
//   data_o       registered result, holds the last completed value
//   zero_o       registered flag, 1 when data_o is all zeros
//   busy_o       1 while a multiply is iterating
//   done_o       1 in the cycle data_o/zero_o first show a new result
//   dbg_state_o  current FSM state (IDLE=0, MUL=1, DONE=2)
//
// Handshake: a request is taken on a rising edge where start_i=1 and the FSM
// is in IDLE or DONE; operands and opcode are captured on that edge. There is
// no backpressure and no queuing: a request seen while busy_o=1 is dropped.
// ---------------------------------------------------------------------------
module alu_multicycle #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [2:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    output logic [DATA_W-1:0] data_o,
    output logic              zero_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        dbg_state_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;

    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [DATA_W-1:0] acc_q,    acc_d;     // running partial product
    logic [DATA_W-1:0] mcand_q,  mcand_d;   // A, shifted left each step
    logic [DATA_W-1:0] mplier_q, mplier_d;  // B, shifted right each step
    logic [DATA_W-1:0] data_q,   data_d;
    logic              zero_q,   zero_d;

    logic              accept;
    logic [DATA_W-1:0] single_res;
    logic [DATA_W-1:0] acc_step;

    assign accept = start_i && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        single_res = '0;
        case (ALUCtrl_i)
            OP_ADD:  single_res = data1_i + data2_i;
            OP_SUB:  single_res = data1_i - data2_i;
            OP_AND:  single_res = data1_i & data2_i;
            OP_OR:   single_res = data1_i | data2_i;
            default: single_res = '0;
        endcase
    end

    // Low DATA_W bits only: bits shifted out of mcand can never reach them.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        data_d   = data_q;
        zero_d   = zero_q;
        case (state_q)
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    data_d  = acc_step;
                    zero_d  = (acc_step == '0);
                    state_d = DONE;
                end
            end
            default: begin // IDLE, DONE
                if (accept) begin
                    cnt_d = '0;
                    if (ALUCtrl_i == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = data1_i;
                        mplier_d = data2_i;
                        state_d  = MUL;
                    end else begin
                        data_d  = single_res;
                        zero_d  = (single_res == '0);
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            data_q   <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
        end
    end

    assign data_o      = data_q;
    assign zero_o      = zero_q;
    assign busy_o      = (state_q == MUL);
    assign done_o      = (state_q == DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [2:0]   ALUCtrl_i = 3'b000;
  logic [W-1:0] data1_i = '0;
  logic [W-1:0] data2_i = '0;
  logic [W-1:0] data_o;
  logic         zero_o;
  logic         busy_o;
  logic         done_o;
  logic [1:0]   dbg_state_o;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  alu_multicycle #(.DATA_W(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .ALUCtrl_i   (ALUCtrl_i),
    .data1_i     (data1_i),
    .data2_i     (data2_i),
    .data_o      (data_o),
    .zero_o      (zero_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset block
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: the result a request produces and how many cycles
  // the machine stays busy before showing it
  function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b011:  return p[W-1:0];
      default: return '0;
    endcase
  endfunction

  int           m_remain = 0;
  logic [W-1:0] m_pend = '0;
  logic [W-1:0] m_data = '0;
  logic         m_zero = 1'b1;
  logic         m_done = 1'b0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_remain = 0;
      m_data   = '0;
      m_zero   = 1'b1;
      m_done   = 1'b0;
    end else if (m_remain > 0) begin
      m_remain = m_remain - 1;
      m_done   = (m_remain == 0);
      if (m_remain == 0) begin
        m_data = m_pend;
        m_zero = (m_pend == '0);
      end
    end else if (start_i) begin
      if (ALUCtrl_i == 3'b011) begin
        m_remain = W;
        m_pend   = alu_ref(ALUCtrl_i, data1_i, data2_i);
        m_done   = 1'b0;
      end else begin
        m_data = alu_ref(ALUCtrl_i, data1_i, data2_i);
        m_zero = (m_data == '0);
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // compare process: every cycle once reset has been applied
  always @(posedge clk_i) begin
    #1;
    if (chk_en) begin
      check("cyc_data", data_o, m_data);
      check("cyc_zero", W'(zero_o), W'(m_zero));
      check("cyc_busy", W'(busy_o), W'(m_remain > 0));
      check("cyc_done", W'(done_o), W'(m_done));
    end
  end

  // driver tasks: inputs change #1 after an edge, so the next edge accepts
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    tick();
    start_i = 1'b0;
  endtask

  // runs from the first cycle after acceptance; returns cycle index of done_o
  task automatic wait_done(output int cyc, output int busy_cnt, input bit disturb);
    cyc = 1;
    busy_cnt = 0;
    while (!done_o && cyc < 100) begin
      if (busy_o) busy_cnt++;
      if (disturb && cyc == 5) begin
        start_i = 1'b1; ALUCtrl_i = 3'b010; data1_i = 32'h1234; data2_i = 32'h1;
      end
      if (disturb && cyc == 8) start_i = 1'b0;
      if (disturb && cyc == 20) begin
        start_i = 1'b1; ALUCtrl_i = 3'b011; data1_i = 32'h0; data2_i = 32'h0;
      end
      if (disturb && cyc == 21) start_i = 1'b0;
      tick();
      cyc++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL mul_timeout: no done_o within %0d cycles", cyc);
    end
  endtask

  int cyc, bc;

  initial begin
    repeat (2) tick();
    chk_en = 1'b1;
    check("rst_data", data_o, 32'h0);
    check("rst_zero", W'(zero_o), 32'h1);
    check("rst_busy", W'(busy_o), 32'h0);
    check("rst_done", W'(done_o), 32'h0);
    rst_i = 1'b0;
    tick();

    // single-cycle operations
    issue(3'b010, 32'd5, 32'd7);
    check("add_data", data_o, 32'd12);
    check("add_zero", W'(zero_o), 32'h0);
    check("add_done", W'(done_o), 32'h1);
    tick();
    check("add_done_clr", W'(done_o), 32'h0);
    check("add_hold", data_o, 32'd12);

    issue(3'b110, 32'd9, 32'd9);
    check("sub_eq_data", data_o, 32'h0);
    check("sub_eq_zero", W'(zero_o), 32'h1);
    tick();
    issue(3'b110, 32'd0, 32'd1);
    check("sub_wrap_data", data_o, 32'hFFFF_FFFF);
    check("sub_wrap_zero", W'(zero_o), 32'h0);
    tick();
    issue(3'b001, 32'h0000_00A0, 32'h0000_0005);
    check("or_data", data_o, 32'h0000_00A5);
    issue(3'b010, 32'hFFFF_FFFF, 32'h2);   // back-to-back from DONE
    check("add_wrap_data", data_o, 32'h1);
    check("add_b2b_done", W'(done_o), 32'h1);
    tick();

    // multiply with disturbances while busy
    issue(3'b011, 32'hFFFF_FFFF, 32'd3);
    data1_i = 32'h5; data2_i = 32'h5; ALUCtrl_i = 3'b000;
    wait_done(cyc, bc, 1'b1);
    check("mul_done_cycle", 32'(cyc), 32'd33);
    check("mul_busy_cycles", 32'(bc), 32'd32);
    check("mul_data", data_o, 32'hFFFF_FFFD);
    check("mul_zero", W'(zero_o), 32'h0);
    tick();
    check("mul_no_extra", W'(done_o | busy_o), 32'h0);

    // multiply then AND accepted in the DONE cycle
    issue(3'b011, 32'd6, 32'd7);
    wait_done(cyc, bc, 1'b0);
    check("mul67_cycle", 32'(cyc), 32'd33);
    check("mul67_data", data_o, 32'd42);
    issue(3'b000, 32'h0000_F0F0, 32'h0000_0FF0);
    check("and_b2b_data", data_o, 32'h0000_00F0);
    check("and_b2b_done", W'(done_o), 32'h1);
    tick();

    // multiply whose low word is zero
    issue(3'b011, 32'h0001_0000, 32'h0001_0000);
    wait_done(cyc, bc, 1'b0);
    check("mulz_data", data_o, 32'h0);
    check("mulz_zero", W'(zero_o), 32'h1);
    tick();

    // reset in the middle of a multiply
    issue(3'b010, 32'd1, 32'd1);
    tick();
    issue(3'b011, 32'd3, 32'd4);
    repeat (8) tick();
    rst_i = 1'b1;
    start_i = 1'b1;   // reset must win over start
    ALUCtrl_i = 3'b010;
    tick();
    rst_i = 1'b0;
    start_i = 1'b0;
    check("abort_data", data_o, 32'h0);
    check("abort_zero", W'(zero_o), 32'h1);
    check("abort_busy", W'(busy_o), 32'h0);
    check("abort_done", W'(done_o), 32'h0);
    bc = 0;
    repeat (40) begin
      tick();
      if (done_o) bc++;
    end
    check("abort_no_done", 32'(bc), 32'd0);

    // undefined opcodes
    issue(3'b010, 32'd2, 32'd3);
    check("pre_undef", data_o, 32'd5);
    tick();
    issue(3'b111, 32'h0000_FFFF, 32'h0000_FFFF);
    check("undef111_data", data_o, 32'h0);
    check("undef111_zero", W'(zero_o), 32'h1);
    check("undef111_done", W'(done_o), 32'h1);
    tick();
    check("undef111_pulse", W'(done_o), 32'h0);
    issue(3'b100, 32'h8, 32'h8);
    check("undef100_data", data_o, 32'h0);
    issue(3'b101, 32'h8, 32'h8);
    check("undef101_data", data_o, 32'h0);
    repeat (2) tick();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
